// File: rtl/bit_fetch.sv
// Bit reservoir between the encoder byte FIFO and the constellation mapper.
// Optional symbol-boundary flush input is enabled by defining BIT_FETCH_FLUSH_EN.
module bit_fetch #(
    parameter int DWIDTH  = 8,
    parameter int MAXBITS = 15,
    parameter int NWIDTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fifo_empty_i,
    input  logic [DWIDTH-1:0]  fifo_data_i,
    output logic               fifo_re_o,
    input  logic               req_i,
    input  logic [NWIDTH-1:0]  nbits_i,
`ifdef BIT_FETCH_FLUSH_EN
    input  logic               flush_i,
`endif
    output logic               ready_o,
    output logic [MAXBITS-1:0] bits_o,
    output logic               valid_o,
    output logic [4:0]         fill_o
);

    localparam int RW = MAXBITS + DWIDTH;

    logic [RW-1:0]      res_q, res_d;
    logic [4:0]         fill_q, fill_d;
    logic               pend_q;
    logic               valid_q;
    logic [MAXBITS-1:0] bits_q, bits_d;

    logic               flush;
    logic [4:0]         n_ext;
    logic [4:0]         n_c;
    logic               accept;
    logic               append;
    logic               re;
    logic [4:0]         fill_shift;
    logic [RW-1:0]      res_shift;
    logic [RW-1:0]      byte_ext;
    logic [MAXBITS-1:0] mask;

`ifdef BIT_FETCH_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        n_ext = 5'(nbits_i);
        n_c   = (n_ext > 5'(MAXBITS)) ? 5'(MAXBITS) : n_ext;

        // Readiness only counts bits already in the reservoir, not the byte landing now.
        ready_o = !flush && (fill_q >= n_c);
        accept  = req_i && ready_o;

        // A byte returning while flushing is dropped; no new read starts during flush.
        append = pend_q && !flush;
        re     = !reset && !flush && !pend_q && !fifo_empty_i && (fill_q <= 5'(MAXBITS));

        mask   = {MAXBITS{1'b1}} >> (5'(MAXBITS) - n_c);
        bits_d = res_q[MAXBITS-1:0] & mask;

        fill_shift = accept ? (fill_q - n_c) : fill_q;
        res_shift  = accept ? (res_q >> n_c) : res_q;
        byte_ext   = RW'(fifo_data_i) << fill_shift;

        res_d  = res_shift;
        fill_d = fill_shift;
        if (append) begin
            res_d  = res_shift | byte_ext;
            fill_d = fill_shift + 5'(DWIDTH);
        end
        if (flush) begin
            res_d  = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q   <= '0;
            fill_q  <= '0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            bits_q  <= '0;
        end else begin
            res_q   <= res_d;
            fill_q  <= fill_d;
            pend_q  <= re;
            valid_q <= accept;
            bits_q  <= accept ? bits_d : '0;
        end
    end

    assign fifo_re_o = re;
    assign valid_o   = valid_q;
    assign bits_o    = bits_q;
    assign fill_o    = fill_q;

endmodule

// File: tb/tb_bit_fetch.sv
// Directed bench for bit_fetch: FIFO model, bit-level reference stream and
// an expected-result queue checked whenever valid_o pulses.
module tb_bit_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_empty_i;
  logic [7:0]  fifo_data_i;
  logic        fifo_re_o;
  logic        req_i;
  logic [3:0]  nbits_i;
  logic        ready_o;
  logic [14:0] bits_o;
  logic        valid_o;
  logic [4:0]  fill_o;
`ifdef BIT_FETCH_FLUSH_EN
  logic        flush_i;
`endif

  int checks = 0;
  int errors = 0;

  logic [14:0] exp_q[$];
  logic [7:0]  fifo_q[$];
  bit          mbits[$];
  logic        re_seen = 1'b0;

  always #5 clk = ~clk;

  bit_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_re_o    (fifo_re_o),
    .req_i        (req_i),
    .nbits_i      (nbits_i),
`ifdef BIT_FETCH_FLUSH_EN
    .flush_i      (flush_i),
`endif
    .ready_o      (ready_o),
    .bits_o       (bits_o),
    .valid_o      (valid_o),
    .fill_o       (fill_o)
  );

  // FIFO model: read data appears in the cycle after fifo_re_o
  always @(negedge clk) re_seen = fifo_re_o;
  always @(posedge clk) begin
    #1;
    if (re_seen && fifo_q.size() > 0) fifo_data_i = fifo_q.pop_front();
    fifo_empty_i = (fifo_q.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid_o pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!reset) begin
      if (fifo_empty_i === 1'b1) chk("re_while_empty", 32'(fifo_re_o), 32'd0);
      if (valid_o === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 32'(valid_o), 32'd0);
        else chk("bits_o", 32'(bits_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty_i = 1'b0;
    for (int i = 0; i < 8; i++) mbits.push_back(b[i]);
  endtask

  function automatic logic [14:0] take_bits(input int n);
    logic [14:0] e;
    e = '0;
    for (int i = 0; i < n; i++) e[i] = mbits.pop_front();
    return e;
  endfunction

  task automatic reset_dut();
    step();
    reset = 1'b1;
    req_i = 1'b0;
    nbits_i = '0;
`ifdef BIT_FETCH_FLUSH_EN
    flush_i = 1'b0;
`endif
    fifo_q.delete();
    mbits.delete();
    fifo_empty_i = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Drive a request, hold it until ready_o, then expect the result next cycle
  task automatic do_req(input int n);
    int waited;
    waited = 0;
    step();
    req_i = 1'b1;
    nbits_i = 4'(n);
    @(negedge clk);
    while (!ready_o && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_o) chk("req_timeout", 32'(ready_o), 32'd1);
    else exp_q.push_back(take_bits(n));
    step();
    req_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    automatic int fill_tbl[8] = '{8, 5, 10, 7, 12, 9, 14, 11};
    int waited;

    reset = 1'b1;
    req_i = 1'b0;
    nbits_i = '0;
    fifo_empty_i = 1'b1;
    fifo_data_i = '0;
`ifdef BIT_FETCH_FLUSH_EN
    flush_i = 1'b0;
`endif

    // Reset with FIFO holding 0xAA
    step();
    step();
    push_byte(8'hAA);
    nbits_i = 4'd1;
    @(negedge clk);
    chk("rst_fill", 32'(fill_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_bits", 32'(bits_o), 32'd0);
    chk("rst_re", 32'(fifo_re_o), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t1_re_c0", 32'(fifo_re_o), 32'd1);
    chk("t1_ready_c0", 32'(ready_o), 32'd0);
    @(negedge clk);
    chk("t1_re_c1", 32'(fifo_re_o), 32'd0);
    chk("t1_ready_c1", 32'(ready_o), 32'd0);
    @(negedge clk);
    chk("t1_fill_c2", 32'(fill_o), 32'd8);
    chk("t1_ready_c2", 32'(ready_o), 32'd1);
    chk("t1_re_c2", 32'(fifo_re_o), 32'd0);
    do_req(4);
    chk("t1_fill_4", 32'(fill_o), 32'd4);
    do_req(4);
    chk("t1_fill_0", 32'(fill_o), 32'd0);

    // 15-bit request needs two bytes
    step();
    push_byte(8'h70);
    push_byte(8'h71);
    nbits_i = 4'd15;
    @(negedge clk);
    chk("t2_not_ready", 32'(ready_o), 32'd0);
    do_req(15);
    chk("t2_fill", 32'(fill_o), 32'd1);
    do_req(1);
    chk("t2_drained", 32'(fill_o), 32'd0);

    // Continuous 3-bit requests against a 0xFF byte stream
    step();
    for (int i = 0; i < 20; i++) push_byte(8'hFF);
    req_i = 1'b1;
    nbits_i = 4'd3;
    waited = 0;
    @(negedge clk);
    while (!ready_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("t3_first_ready", 32'(waited), 32'd2);
    for (int c = 0; c < 40; c++) begin
      chk("t3_no_bubble", 32'(ready_o), 32'd1);
      if (c < 8) chk("t3_fill", 32'(fill_o), 32'(fill_tbl[c]));
      if (ready_o) exp_q.push_back(take_bits(3));
      step();
      if (c == 39) req_i = 1'b0;
      @(negedge clk);
    end
    reset_dut();

    // Empty FIFO with a held request, then a single byte arrives
    req_i = 1'b1;
    nbits_i = 4'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_hold_ready", 32'(ready_o), 32'd0);
      chk("t4_hold_re", 32'(fifo_re_o), 32'd0);
    end
    step();
    push_byte(8'h03);
    @(negedge clk);
    chk("t4_re", 32'(fifo_re_o), 32'd1);
    @(negedge clk);
    chk("t4_ready_land", 32'(ready_o), 32'd0);
    @(negedge clk);
    chk("t4_ready", 32'(ready_o), 32'd1);
    if (ready_o) exp_q.push_back(take_bits(2));
    step();
    req_i = 1'b0;
    @(negedge clk);
    chk("t4_valid", 32'(valid_o), 32'd1);
    chk("t4_bits", 32'(bits_o), 32'h3);
    chk("t4_fill", 32'(fill_o), 32'd6);
    do_req(0);
    chk("t5_zero_fill6", 32'(fill_o), 32'd6);

    // Zero-bit request on an empty reservoir
    reset_dut();
    @(negedge clk);
    chk("t5_fill_before", 32'(fill_o), 32'd0);
    do_req(0);
    chk("t5_fill_after", 32'(fill_o), 32'd0);

    // Reset while a FIFO read is outstanding drops the byte
    reset_dut();
    push_byte(8'h5A);
    @(negedge clk);
    chk("t6_re", 32'(fifo_re_o), 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    mbits.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_fill", 32'(fill_o), 32'd0);
    end

`ifdef BIT_FETCH_FLUSH_EN
    // Flush with fill 5 and a read in flight
    reset_dut();
    push_byte(8'h0F);
    do_req(3);
    chk("t7_fill5", 32'(fill_o), 32'd5);
    step();
    push_byte(8'hC3);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    mbits.delete();
    @(negedge clk);
    chk("t7_flush_fill", 32'(fill_o), 32'd0);
    @(negedge clk);
    chk("t7_flush_fill2", 32'(fill_o), 32'd0);
`endif

    step();
    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bit_fetch.md
Name: bit_fetch

Overview:
- Stage directly downstream of the constellation-encoder input FIFO (8-bit bytes).
- Pulls bytes from the FIFO into a bit reservoir and delivers an exact number of bits (0..15) per tone request to the constellation mapper.
- Hides the FIFO's one-cycle read latency and byte granularity from the mapper.

Parameters:
- DWIDTH, 8, FIFO data width in bits.
- MAXBITS, 15, maximum bits per request; reservoir width is MAXBITS+DWIDTH (23).
- NWIDTH, 4, width of the bit-count request field.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_data_i  input  DWIDTH  FIFO read data; valid in the cycle after fifo_re_o=1.
- fifo_re_o  output  1  FIFO read enable.
- req_i  input  1  mapper requests nbits_i bits this cycle.
- nbits_i  input  NWIDTH  bits requested, 0..MAXBITS.
- ready_o  output  1  combinational; request can be served this cycle.
- bits_o  output  MAXBITS  delivered bits, right-aligned, upper bits zero.
- valid_o  output  1  bits_o valid; one-cycle pulse.
- fill_o  output  5  current reservoir fill count, 0..23.

Behaviour:
- Reset: fifo_re_o=0, valid_o=0, bits_o=0, fill_o=0, reservoir cleared, pending flag cleared.
- Reservoir: shift register; bit 0 is the next bit out. A byte is appended at position fill, LSB of the byte first.
- Refill: fifo_re_o=1 when fill<=MAXBITS, no read is pending, and fifo_empty_i=0. This sets pending.
  - Next cycle: fifo_data_i is appended, fill increases by 8, pending clears.
  - fifo_re_o is never asserted while fifo_empty_i=1.
  - At most one read is outstanding.
- ready_o = (fill >= nbits_i). Computed combinationally from the registered fill and nbits_i. It does not count the byte arriving in the same cycle.
- Accept: req_i=1 and ready_o=1.
  - Next cycle: valid_o=1 and bits_o = reservoir[nbits_i-1:0] zero-extended.
  - Reservoir shifts right by nbits_i; fill decreases by nbits_i.
  - nbits_i=0 with req_i=1 is always accepted: valid_o=1, bits_o=0, fill unchanged.
- req_i=1 with ready_o=0: ignored; no valid_o. The mapper holds req_i and nbits_i until ready_o=1.
- Simultaneous accept and byte arrival in one cycle:
  - new fill = fill - n + 8.
  - Byte lands at position fill - n, after the shift.
  - No bits are lost or duplicated.
- Latency: request to valid_o is 1 cycle. An empty reservoir with a non-empty FIFO gives first ready_o=1 two cycles after reset release (read, then append).
- Fill bound: fill never exceeds MAXBITS+DWIDTH. Reads are issued only at fill<=15.
- nbits_i > MAXBITS is illegal; the implementation clamps it to MAXBITS.
- Reset mid-operation: a pending FIFO byte is discarded, i.e. not appended. The reservoir is cleared.

Optional Feature:
- Macro: BIT_FETCH_FLUSH_EN.
- Defined: adds input flush_i (1 bit), used at DMT symbol boundaries.
  - flush_i=1 clears the reservoir and fill next cycle.
  - Any byte returning that cycle or next from a pending read is dropped.
  - No request is accepted in the flush cycle.
  - flush_i has priority over req_i and refill.
- Not defined: port is absent; the reservoir is only cleared by reset.

Test Plan:
- Reset with FIFO holding 0xAA: fifo_re_o pulses once, then fill_o=8. req nbits=4 -> bits_o=0x00A, fill_o=4; req nbits=4 -> bits_o=0x00A, fill_o=0.
- FIFO holds 0x70,0x71; req nbits=15 -> ready_o=0 until fill reaches 16, then bits_o=0x7170&0x7FFF=0x7170, fill_o=1.
- Continuous req nbits=3 with FIFO bytes 0xFF stream: check every bits_o=0x7 and no bubble once fill>=3. Verify the simultaneous consume+append cycle keeps fill_o correct, e.g. 6-3+8=11.
- FIFO empty, req nbits=2 held: ready_o=0, fifo_re_o never 1, no valid_o. Then write 0x03: bits_o=0x3 two cycles after the write lands.
- req nbits=0 with fill_o=0: valid_o=1, bits_o=0, fill unchanged.
- With BIT_FETCH_FLUSH_EN: fill_o=5 with a pending read, assert flush_i -> fill_o=0 next cycle and the returned byte is not appended. Without the macro, flush_i does not exist.
